// File: rtl/pulse_rate_counter_pkg.sv
// Shared definitions for the pulse-rate counter and its control-loop consumer:
// counts-slice macro, clog2 helper and default window/count sizing.
`ifndef PULSE_RATE_COUNTER_PKG_SV
`define PULSE_RATE_COUNTER_PKG_SV

// Part-select of channel idx inside a flat counts bus of w-bit slices.
`define PRC_SLICE(idx, w) (idx)*(w) +: (w)

package pulse_rate_counter_pkg;

  localparam int PRC_BITS   = 8;
  localparam int PRC_CNT_W  = 16;
  localparam int PRC_WINDOW = 50000;

  // Bits needed to hold 0..value-1; never less than one bit.
  function automatic int prc_clog2(input int value);
    int result;
    result = 1;
    for (int i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(value)) result = i + 1;
    end
    return result;
  endfunction

endpackage

`endif

// File: rtl/pulse_rate_counter_sat.sv
// One saturating event accumulator with a sticky flag that records any
// increment suppressed because the count was already at its maximum.
module sat_event_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             inc,
  output logic [CNT_W-1:0] value,
  output logic             sticky,
  output logic             at_max
);

  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  logic [CNT_W-1:0] r_value;
  logic             r_sticky;
  logic             w_at_max;

  assign w_at_max = &r_value;

  // clear wins over inc: the caller folds a same-cycle event into its own
  // snapshot path before the accumulator restarts.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_value  <= '0;
      r_sticky <= 1'b0;
    end else if (clear) begin
      r_value  <= '0;
      r_sticky <= 1'b0;
    end else if (inc) begin
      if (w_at_max) begin
        r_sticky <= 1'b1;
      end else begin
        r_value <= r_value + ONE;
      end
    end
  end

  assign value  = r_value;
  assign sticky = r_sticky;
  assign at_max = w_at_max;

endmodule

// File: rtl/pulse_rate_counter.sv
// Per-channel event-rate counter: accumulates events over a fixed window of
// clk cycles and publishes a snapshot of all counts plus overflow flags.
module pulse_rate_counter
  import pulse_rate_counter_pkg::*;
#(
  parameter int BITS   = PRC_BITS,
  parameter int CNT_W  = PRC_CNT_W,
  parameter int WINDOW = PRC_WINDOW
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         enable,
  input  logic [BITS-1:0]              in,
  output logic [BITS*CNT_W-1:0]        counts,
  output logic [BITS-1:0]              ovf,
  output logic                         valid,
  output logic [prc_clog2(WINDOW)-1:0] window_cnt
);

  localparam int               WIN_W = prc_clog2(WINDOW);
  localparam logic [WIN_W-1:0] LAST  = WIN_W'(WINDOW - 1);
  localparam logic [WIN_W-1:0] ONE   = WIN_W'(1);

  logic [WIN_W-1:0]       r_window_cnt;
  logic [BITS*CNT_W-1:0]  r_counts;
  logic [BITS-1:0]        r_ovf;
  logic                   r_valid;

  logic                   w_terminal;
  logic                   w_clear;
  logic [BITS-1:0]        w_inc;
  logic [BITS*CNT_W-1:0]  w_next_counts;
  logic [BITS-1:0]        w_next_ovf;

  assign w_inc      = in & {BITS{enable}};
  assign w_terminal = enable & (r_window_cnt == LAST);
  assign w_clear    = ~enable | w_terminal;

  // The snapshot value includes the terminal cycle's own event, saturated.
  for (genvar g = 0; g < BITS; g++) begin : g_ch
    logic [CNT_W-1:0] w_value;
    logic             w_sticky;
    logic             w_at_max;

    sat_event_counter #(
      .CNT_W (CNT_W)
    ) u_cnt (
      .clk    (clk),
      .rst    (rst),
      .clear  (w_clear),
      .inc    (w_inc[g]),
      .value  (w_value),
      .sticky (w_sticky),
      .at_max (w_at_max)
    );

    assign w_next_counts[`PRC_SLICE(g, CNT_W)] =
      w_at_max ? w_value : w_value + CNT_W'(w_inc[g]);
    assign w_next_ovf[g] = w_sticky | (w_at_max & w_inc[g]);
  end

  // valid is a one-cycle strobe with no back-pressure: counts/ovf change only
  // together with valid (or at reset) and must be captured while valid=1.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_window_cnt <= '0;
      r_counts     <= '0;
      r_ovf        <= '0;
      r_valid      <= 1'b0;
    end else if (!enable) begin
      r_window_cnt <= '0;
      r_valid      <= 1'b0;
    end else if (w_terminal) begin
      r_window_cnt <= '0;
      r_counts     <= w_next_counts;
      r_ovf        <= w_next_ovf;
      r_valid      <= 1'b1;
    end else begin
      r_window_cnt <= r_window_cnt + ONE;
      r_valid      <= 1'b0;
    end
  end

  assign counts     = r_counts;
  assign ovf        = r_ovf;
  assign valid      = r_valid;
  assign window_cnt = r_window_cnt;

endmodule

// File: tb/tb_pulse_rate_counter.sv
// Directed bench: instance A (CNT_W=16, WINDOW=10) and instance B
// (CNT_W=3, WINDOW=12) driven through hand-computed windows.
module tb_pulse_rate_counter;

  logic         clk;
  logic         rst_a, en_a;
  logic [7:0]   in_a;
  logic [127:0] counts_a;
  logic [7:0]   ovf_a;
  logic         valid_a;
  logic [3:0]   wcnt_a;

  logic         rst_b, en_b;
  logic [7:0]   in_b;
  logic [23:0]  counts_b;
  logic [7:0]   ovf_b;
  logic         valid_b;
  logic [3:0]   wcnt_b;

  int tests;
  int fails;

  pulse_rate_counter #(.BITS(8), .CNT_W(16), .WINDOW(10)) dut_a (
    .clk        (clk),
    .rst        (rst_a),
    .enable     (en_a),
    .in         (in_a),
    .counts     (counts_a),
    .ovf        (ovf_a),
    .valid      (valid_a),
    .window_cnt (wcnt_a)
  );

  pulse_rate_counter #(.BITS(8), .CNT_W(3), .WINDOW(12)) dut_b (
    .clk        (clk),
    .rst        (rst_b),
    .enable     (en_b),
    .in         (in_b),
    .counts     (counts_b),
    .ovf        (ovf_b),
    .valid      (valid_b),
    .window_cnt (wcnt_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One full window on instance A, starting with window_cnt==0.
  task automatic window_a(input string tag, input logic [7:0] v [10]);
    for (int c = 0; c < 10; c++) begin
      in_a = v[c];
      tick();
      if (c < 9) begin
        check($sformatf("%s_valid_c%0d", tag, c), {127'd0, valid_a}, 128'd0);
        check($sformatf("%s_wcnt_c%0d", tag, c), {124'd0, wcnt_a}, 128'(c + 1));
      end else begin
        check($sformatf("%s_valid_end", tag), {127'd0, valid_a}, 128'd1);
        check($sformatf("%s_wcnt_end", tag), {124'd0, wcnt_a}, 128'd0);
      end
    end
    in_a = 8'h00;
  endtask

  task automatic window_b(input string tag, input logic [7:0] v [12]);
    for (int c = 0; c < 12; c++) begin
      in_b = v[c];
      tick();
      if (c < 11) check($sformatf("%s_valid_c%0d", tag, c), {127'd0, valid_b}, 128'd0);
      else        check($sformatf("%s_valid_end", tag), {127'd0, valid_b}, 128'd1);
    end
    in_b = 8'h00;
  endtask

  logic [7:0]   va [10];
  logic [7:0]   vb [12];
  logic [127:0] exp_counts;

  initial begin
    tests = 0;
    fails = 0;
    rst_a = 1'b1; rst_b = 1'b1;
    en_a  = 1'b0; en_b  = 1'b0;
    in_a  = 8'h00; in_b = 8'h00;
    repeat (3) tick();

    check("reset_counts_a", counts_a, 128'd0);
    check("reset_ovf_a", {120'd0, ovf_a}, 128'd0);
    check("reset_valid_a", {127'd0, valid_a}, 128'd0);
    check("reset_wcnt_a", {124'd0, wcnt_a}, 128'd0);
    check("reset_counts_b", {104'd0, counts_b}, 128'd0);

    rst_a = 1'b0; rst_b = 1'b0;
    en_a  = 1'b1;

    // ch0 at cycles 0,2,4; ch3 held for the whole window.
    va = '{8'h09, 8'h08, 8'h09, 8'h08, 8'h09, 8'h08, 8'h08, 8'h08, 8'h08, 8'h08};
    window_a("basic", va);
    exp_counts = '0;
    exp_counts[0 +: 16]  = 16'd3;
    exp_counts[48 +: 16] = 16'd10;
    check("basic_counts", counts_a, exp_counts);
    check("basic_ovf", {120'd0, ovf_a}, 128'd0);

    // Event only in the terminal cycle belongs to the closing window.
    va = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h02};
    window_a("term", va);
    exp_counts = '0;
    exp_counts[16 +: 16] = 16'd1;
    check("term_counts", counts_a, exp_counts);
    va = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    window_a("after_term", va);
    check("after_term_counts", counts_a, 128'd0);

    // All channels in one cycle.
    va = '{8'h00, 8'h00, 8'h00, 8'hFF, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    window_a("all", va);
    exp_counts = '0;
    for (int i = 0; i < 8; i++) exp_counts[i*16 +: 16] = 16'd1;
    check("all_counts", counts_a, exp_counts);

    // Async reset mid-window after 3 events on ch0.
    for (int c = 0; c < 4; c++) begin
      in_a = (c < 3) ? 8'h01 : 8'h00;
      tick();
    end
    check("pre_rst_wcnt", {124'd0, wcnt_a}, 128'd4);
    #2;
    rst_a = 1'b1;
    #1;
    check("async_rst_counts", counts_a, 128'd0);
    check("async_rst_wcnt", {124'd0, wcnt_a}, 128'd0);
    check("async_rst_valid", {127'd0, valid_a}, 128'd0);
    tick();
    rst_a = 1'b0;
    va = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h01, 8'h01, 8'h00, 8'h00, 8'h00};
    window_a("post_rst", va);
    check("post_rst_counts", counts_a, 128'd2);

    // Drop enable at cycle 5, re-enable 4 cycles later.
    for (int c = 0; c < 5; c++) begin
      in_a = 8'h04;
      tick();
    end
    check("pre_drop_wcnt", {124'd0, wcnt_a}, 128'd5);
    en_a = 1'b0;
    for (int c = 0; c < 4; c++) begin
      tick();
      check($sformatf("drop_valid_c%0d", c), {127'd0, valid_a}, 128'd0);
      check($sformatf("drop_wcnt_c%0d", c), {124'd0, wcnt_a}, 128'd0);
    end
    check("drop_counts_held", counts_a, 128'd2);
    en_a = 1'b1;
    va = '{8'h20, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h20};
    window_a("reen", va);
    exp_counts = '0;
    exp_counts[80 +: 16] = 16'd2;
    check("reen_counts", counts_a, exp_counts);

    // Instance B: 3-bit counts saturate at 7.
    en_b = 1'b1;
    for (int c = 0; c < 12; c++) vb[c] = 8'h04;
    window_b("sat", vb);
    check("sat_counts", {104'd0, counts_b}, 128'h1C0);
    check("sat_ovf", {120'd0, ovf_b}, 128'h04);

    for (int c = 0; c < 12; c++) vb[c] = (c == 1 || c == 7) ? 8'h04 : 8'h00;
    window_b("unsat", vb);
    check("unsat_counts", {104'd0, counts_b}, 128'h080);
    check("unsat_ovf", {120'd0, ovf_b}, 128'h00);

    // ch0 reaches 7 before the terminal cycle; the terminal event overflows.
    for (int c = 0; c < 12; c++) vb[c] = (c >= 4) ? 8'h01 : 8'h00;
    window_b("term_sat", vb);
    check("term_sat_counts", {104'd0, counts_b}, 128'h007);
    check("term_sat_ovf", {120'd0, ovf_b}, 128'h01);

    tick();
    check("valid_b_strobe", {127'd0, valid_b}, 128'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
